// File: rtl/fpg8_mem_pkg.sv
// Shared types for the FPG8 memory responder: FSM states, access kinds, I/O window offsets.
package fpg8_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_READ  = 2'd0,
        KIND_WRITE = 2'd1,
        KIND_BOTH  = 2'd2
    } kind_t;

    localparam logic [1:0] IO_LED = 2'd0;
    localparam logic [1:0] IO_SW  = 2'd1;
    localparam logic [1:0] IO_CYC = 2'd2;
    localparam logic [1:0] IO_SCR = 2'd3;

    // Simultaneous read and write requests collapse to a non-modifying read.
    function automatic kind_t decode_kind(input logic rd, input logic wr);
        if (rd && wr) return KIND_BOTH;
        if (wr)       return KIND_WRITE;
        return KIND_READ;
    endfunction

endpackage

// File: rtl/fpg8_mem_responder_io.sv
// I/O window registers (LED, scratch, free-running cycle counter) and their read mux.
module fpg8_io_regs
    import fpg8_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr,
    input  logic [1:0]  i_off,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_sw,
    output logic [15:0] o_rdata,
    output logic [15:0] o_led
);

    logic [15:0] r_led;
    logic [15:0] r_scr;
    logic [15:0] r_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
            r_scr <= '0;
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + 16'd1;
            // Writes to the switch and counter offsets are read-only and silently dropped.
            if (i_wr && i_off == IO_LED) r_led <= i_wdata;
            if (i_wr && i_off == IO_SCR) r_scr <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_off)
            IO_LED:  o_rdata = r_led;
            IO_SW:   o_rdata = i_sw;
            IO_CYC:  o_rdata = r_cyc;
            IO_SCR:  o_rdata = r_scr;
            default: o_rdata = '0;
        endcase
    end

    assign o_led = r_led;

endmodule

// File: rtl/fpg8_mem_responder.sv
// FPG8 memory responder: RAM plus a 4-word I/O window behind a wait-stated ready pulse.
// Optional error tracking (err/err_addr) is enabled by defining FPG8_MEMRESP_ERR_EN.
module fpg8_mem_responder
    import fpg8_mem_pkg::*;
#(
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        r_en,
    input  logic        w_en,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output state_t      dbg_state
`ifdef FPG8_MEMRESP_ERR_EN
    ,
    output logic        err,
    output logic [15:0] err_addr
`endif
);

    localparam int         AW      = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    // Handshake: a request (r_en/w_en level) is accepted in IDLE only while armed;
    // ready pulses for exactly one cycle and rdata is valid while ready=1.
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic [3:0]  r_wait_cnt;
    logic        r_armed;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    kind_t       r_kind;
    logic        r_ready;
    logic [15:0] r_rdata;
    logic [15:0] r_ram [MEM_DEPTH];

    logic        w_ram_hit;
    logic        w_io_hit;
    logic        w_commit;
    logic        w_io_wr;
    logic [15:0] w_io_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && (r_en || w_en)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: if (r_wait_cnt == 4'd0) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_ram_hit = (r_addr[15:AW] == '0);
    assign w_io_hit  = !w_ram_hit && (r_addr[15:2] == IO_BASE[15:2]);
    assign w_commit  = (r_state == ST_RESP) && (r_kind == KIND_WRITE);
    assign w_io_wr   = w_commit && w_io_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_armed    <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_kind     <= KIND_READ;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ready <= (r_state == ST_RESP);
            if (w_accept) begin
                r_addr     <= addr;
                r_wdata    <= wdata;
                r_kind     <= decode_kind(r_en, w_en);
                r_wait_cnt <= WS_LOAD;
                r_armed    <= 1'b0;
            end else begin
                // Re-arm only after seeing both enables low, so held requests never repeat.
                if (!r_en && !w_en) r_armed <= 1'b1;
                if (r_state == ST_WAIT && r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (r_state == ST_RESP && r_kind != KIND_WRITE) begin
                if (w_ram_hit)     r_rdata <= r_ram[r_addr[AW-1:0]];
                else if (w_io_hit) r_rdata <= w_io_rdata;
                else               r_rdata <= 16'h0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_ram_hit) r_ram[r_addr[AW-1:0]] <= r_wdata;
    end

    fpg8_io_regs u_io (
        .clk     (clk),
        .rst     (reset),
        .i_wr    (w_io_wr),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_sw    (sw_in),
        .o_rdata (w_io_rdata),
        .o_led   (led_out)
    );

`ifdef FPG8_MEMRESP_ERR_EN
    logic w_err_set;
    assign w_err_set = (r_state == ST_RESP) &&
                       ((!w_ram_hit && !w_io_hit) ||
                        (w_commit && w_io_hit && (r_addr[1:0] == IO_SW || r_addr[1:0] == IO_CYC)) ||
                        (r_kind == KIND_BOTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (w_err_set) begin
            err      <= 1'b1;
            err_addr <= r_addr;
        end else if (w_io_wr && r_addr[1:0] == IO_SCR) begin
            err <= 1'b0;
        end
    end
`endif

    assign rdata     = r_rdata;
    assign ready     = r_ready;
    assign dbg_state = r_state;

endmodule
